// File: rtl/down_counter_timer_pkg.sv
// Shared types for the loadable down-counter timer.
package down_counter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      StIdle,
      StRun
   } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer; the slave modport is the timer side.
interface down_counter_timer_if
   import down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             en;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, start, stop, en,
      input  count, busy, done
   );

   modport slave (
      input  load, load_val, start, stop, en,
      output count, busy, done
   );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable start/stop down-counter with a one-cycle done pulse at terminal count.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module down_counter_timer
   import down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                 clk,
   input logic                 reset,
   down_counter_timer_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             at_one;
   logic             at_zero;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             periodic;
   assign periodic = (reload_q != '0);
`endif

   assign at_one  = (count_q == WIDTH'(1));
   assign at_zero = (count_q == '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         done_q   <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         done_q   <= done_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   // Next-state logic: load > stop > start > decrement
   always_comb begin
      state_d = state_q;
      if (bus.load) begin
         state_d = StIdle;
      end else if (bus.stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start && !at_zero) state_d = StRun;
            end
            StRun: begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
               if (bus.en && at_one && !periodic) state_d = StIdle;
`else
               if (bus.en && at_one) state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath and output logic
   always_comb begin
      count_d = count_q;
      done_d  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      if (bus.load) begin
         count_d = bus.load_val;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
         reload_d = bus.load_val;
`endif
      end else if (bus.stop) begin
         count_d = count_q;
      end else if (state_q == StIdle) begin
         // Starting from zero has nothing to count, so terminal count is immediate.
         if (bus.start && at_zero) done_d = 1'b1;
      end else if (bus.en) begin
         if (at_one) begin
            done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
`endif
         end else if (!at_zero) begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = (state_q == StRun);
   assign bus.done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed vector bench for down_counter_timer (one-shot or auto-reload build).
module tb_down_counter_timer;

   typedef struct {
      logic       load;
      logic [3:0] load_val;
      logic       start;
      logic       stop;
      logic       en;
      logic [3:0] exp_count;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   down_counter_timer_if #(.WIDTH(4)) bus ();

   down_counter_timer #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] c, input logic b, input logic d);
      tests++;
      if (bus.count !== c || bus.busy !== b || bus.done !== d) begin
         fails++;
         $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                  name, bus.count, bus.busy, bus.done, c, b, d);
      end
   endtask

   task automatic drive(input logic l, input logic [3:0] lv, input logic s, input logic sp,
                        input logic e);
      bus.load     = l;
      bus.load_val = lv;
      bus.start    = s;
      bus.stop     = sp;
      bus.en       = e;
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input vec_t v, input string name);
      drive(v.load, v.load_val, v.start, v.stop, v.en);
      @(posedge clk);
      #1;
      check(name, v.exp_count, v.exp_busy, v.exp_done);
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input logic l, input logic [3:0] lv, input logic s, input logic sp,
                               input logic e, input logic [3:0] c, input logic b, input logic d);
      vec_t v;
      v.load = l; v.load_val = lv; v.start = s; v.stop = sp; v.en = e;
      v.exp_count = c; v.exp_busy = b; v.exp_done = d;
      return v;
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      do_reset();
      check("reset_state", 4'd0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      // Periodic: load 2 -> 2,2,1,2,1,2 with done on each reload, then stop holds
      vecs.push_back(mk(1, 4'd2, 0, 0, 0, 4'd2, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd1, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 1, 1));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd1, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 1, 1));
      vecs.push_back(mk(0, 4'd0, 0, 1, 1, 4'd2, 0, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 0, 0));
      // Reload value 0 behaves as one-shot
      vecs.push_back(mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd0, 0, 1));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0));
`else
      // One-shot from 5
      vecs.push_back(mk(1, 4'd5, 0, 0, 0, 4'd5, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd5, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd4, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd3, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd1, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 1));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0));
      // Enable gating from 3
      vecs.push_back(mk(1, 4'd3, 0, 0, 0, 4'd3, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd3, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 0, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 0, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd1, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 1));
      // Load+stop at count 6 in RUN: load wins, no done
      vecs.push_back(mk(1, 4'd7, 0, 0, 0, 4'd7, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd7, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd6, 1, 0));
      vecs.push_back(mk(1, 4'd10, 0, 1, 1, 4'd10, 0, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd10, 0, 0));
      // Preset 0: done after one cycle, never busy
      vecs.push_back(mk(1, 4'd0, 0, 0, 0, 4'd0, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd0, 0, 1));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0));
      // Stop/restart from 8; start while running is ignored
      vecs.push_back(mk(1, 4'd8, 0, 0, 0, 4'd8, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd8, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd7, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd6, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd5, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 1, 1, 4'd5, 0, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd5, 0, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd5, 0, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd5, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd5, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd4, 1, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd3, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd2, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd1, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 1));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0));
      // Max preset, then load during RUN aborts without done
      vecs.push_back(mk(1, 4'd15, 0, 0, 0, 4'd15, 0, 0));
      vecs.push_back(mk(0, 4'd0, 1, 0, 1, 4'd15, 1, 0));
      vecs.push_back(mk(0, 4'd0, 0, 0, 1, 4'd14, 1, 0));
      vecs.push_back(mk(1, 4'd0, 0, 0, 1, 4'd0, 0, 0));
`endif

      foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset mid-run: preset 9, start, three enabled cycles
      step(mk(1, 4'd9, 0, 0, 0, 4'd9, 0, 0), "rst_load");
      step(mk(0, 4'd0, 1, 0, 1, 4'd9, 1, 0), "rst_start");
      step(mk(0, 4'd0, 0, 0, 1, 4'd8, 1, 0), "rst_run1");
      step(mk(0, 4'd0, 0, 0, 1, 4'd7, 1, 0), "rst_run2");
      step(mk(0, 4'd0, 0, 0, 1, 4'd6, 1, 0), "rst_run3");
      reset = 1'b1;
      #1;
      check("rst_async", 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0), "rst_idle1");
      step(mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0), "rst_idle2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, start/stop-controlled down-counter: the count-down counterpart to the team's free-running 4-bit up-counter.
- Takes a preset value, decrements it to zero under an enable, and flags terminal count with a one-cycle done pulse.
- Used as a programmable interval timer / delay generator next to the existing counter blocks.

Parameters:
- WIDTH, 4, bit width of preset and count.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  load request; captures load_val.
- load_val  input  WIDTH  preset value.
- start  input  1  begin counting from current count.
- stop  input  1  abort counting; count holds.
- en  input  1  count enable; decrement only when high.
- count  output  WIDTH  current counter value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at terminal count.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (port reset). All outputs are registered.
- Reset values: count=0, busy=0, done=0, state=IDLE. Reset is applied immediately, including mid-count.
- States: IDLE, RUN. busy is high exactly when state=RUN.
- Per-edge priority: reset > load > stop > start > decrement.
- load (any state):
  - count<=load_val; state<=IDLE; done<=0.
  - A load during RUN aborts the run with no done pulse.
- stop in RUN: state<=IDLE; count holds. stop in IDLE has no effect.
- start in IDLE:
  - count!=0: state<=RUN next edge; count unchanged on that edge.
  - count==0: done pulses next cycle; stays IDLE.
- start in RUN is ignored.
- RUN, en=1:
  - count>1: count<=count-1.
  - count==1: count<=0, done<=1 on the same edge, state<=IDLE.
- RUN, en=0: count holds and state holds.
- Latency: start to done = 1 + N enabled cycles for preset N; N=0 gives 1 cycle.
- No wrap-around: count never decrements below 0 and never leaves 0 without a load.
- done is high for exactly one cycle and is low in every other cycle.
- Max preset 2^WIDTH-1. Width arithmetic is unsigned WIDTH bits throughout.

Optional Feature:
- Macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN.
- Defined:
  - Adds an internal reload register (WIDTH bits) written on every load.
  - In RUN at count==1 with en=1: count<=reload, done pulses, state stays RUN (periodic timer).
  - stop or load exits RUN as above.
  - If the reload value is 0, behaves as one-shot.
- Undefined: one-shot only as described above; no reload register exists.

Decomposition:
- Package down_counter_pkg holds:
  - the state enum (IDLE, RUN);
  - localparam DEFAULT_WIDTH=4.
- No sub-module: the datapath is a single decrementer plus zero/one detect, kept inline.

Test Plan:
- Reset mid-run: preset 9, start, assert reset after 3 enabled cycles -> count=0, busy=0, done=0 immediately (asynchronous); block stays idle after release.
- One-shot: load 5, start, en=1 continuous -> count 5,5,4,3,2,1,0 on successive edges; done high only in the cycle count becomes 0; busy low afterward.
- Enable gating: load 3, start, en toggling 1,0,0,1,1 -> count 3,2,2,2,1,0; done on the final edge only.
- Priority: in RUN with count=6, assert load (load_val=A) and stop together -> count=A, IDLE, no done. Start with preset 0 -> done pulse after 1 cycle, busy never high.
- Stop/restart: load 8, run 3 cycles, stop -> count=5 held for 4 cycles, busy=0; start again -> reaches 0 after 5 enabled cycles with a single done pulse.
- With DOWN_COUNTER_TIMER_AUTO_RELOAD_EN: load 2, start, en=1 -> count 2,2,1,2,1,2...; done every 2nd cycle; stop -> busy=0, count held.
